// File: rtl/video_timing_gen.sv
// video_timing_gen -- raster timing generator for a TMDS/DVI transmitter.
//
// Walks an (hcount, vcount) raster of H_TOTAL x V_TOTAL positions, one step
// per cycle with en=1. Each line and each frame is ordered active, front
// porch, sync, back porch. Every output is registered and is derived from the
// same next-state counter values. This keeps vde, sync, cd and the start
// pulses aligned with the hcount/vcount shown in the same cycle, one cycle
// after the en=1 cycle that caused the step.
//
// Reset parks the counters on the last raster position. The first en=1 cycle
// after reset therefore presents (0,0) with frame_start.
//
// Optional feature: define VIDEO_TEST_PATTERN_EN to add red/green/blue outputs
// that carry eight vertical colour bars, registered alongside vde.

module video_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic [11:0] hcount,
  output logic [11:0] vcount,
  output logic        vde,
  output logic        hsync,
  output logic        vsync,
  output logic [1:0]  cd,
  output logic        line_start,
  output logic        frame_start
`ifdef VIDEO_TEST_PATTERN_EN
  ,
  output logic [7:0]  red,
  output logic [7:0]  green,
  output logic [7:0]  blue
`endif
);

  // Raster geometry, widened to the 12-bit counter width once here.
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [11:0] H_LAST     = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_LAST     = 12'(V_TOTAL - 1);
  localparam logic [11:0] H_ACT      = 12'(H_ACTIVE);
  localparam logic [11:0] V_ACT      = 12'(V_ACTIVE);
  localparam logic [11:0] H_SYNC_BEG = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] H_SYNC_END = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] V_SYNC_BEG = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] V_SYNC_END = 12'(V_ACTIVE + V_FP + V_SYNC);

  // Registered state; every output is driven straight from one of these.
  logic [11:0] hcount_q, hcount_d;
  logic [11:0] vcount_q, vcount_d;
  logic        vde_q, vde_d;
  logic        hsync_q, hsync_d;
  logic        vsync_q, vsync_d;
  logic [1:0]  cd_q, cd_d;
  logic        line_start_q, line_start_d;
  logic        frame_start_q, frame_start_d;

  // Next raster position and the outputs decoded from it; everything holds
  // while en=0, and the start pulses only fire on an actual advance.
  always_comb begin
    hcount_d      = hcount_q;
    vcount_d      = vcount_q;
    vde_d         = vde_q;
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;
    if (en) begin
      if (hcount_q == H_LAST) begin
        hcount_d = 12'd0;
        if (vcount_q == V_LAST) begin
          vcount_d = 12'd0;
        end else begin
          vcount_d = vcount_q + 12'd1;
        end
      end else begin
        hcount_d = hcount_q + 12'd1;
        vcount_d = vcount_q;
      end

      vde_d = (hcount_d < H_ACT) && (vcount_d < V_ACT);

      if ((hcount_d >= H_SYNC_BEG) && (hcount_d < H_SYNC_END)) begin
        hsync_d = HS_POL;
      end else begin
        hsync_d = ~HS_POL;
      end

      // Vertical sync depends on the line only, so it spans whole lines.
      if ((vcount_d >= V_SYNC_BEG) && (vcount_d < V_SYNC_END)) begin
        vsync_d = VS_POL;
      end else begin
        vsync_d = ~VS_POL;
      end

      line_start_d  = (hcount_d == 12'd0);
      frame_start_d = (hcount_d == 12'd0) && (vcount_d == 12'd0);
    end else begin
      hcount_d = hcount_q;
      vcount_d = vcount_q;
    end
    // Control data for the blue-channel encoder follows the polarity-applied syncs.
    cd_d = {vsync_d, hsync_d};
  end

  // State register; reset parks on the last raster position and wins over en.
  always_ff @(posedge clk) begin
    if (rst) begin
      hcount_q      <= H_LAST;
      vcount_q      <= V_LAST;
      vde_q         <= 1'b0;
      hsync_q       <= ~HS_POL;
      vsync_q       <= ~VS_POL;
      cd_q          <= {~VS_POL, ~HS_POL};
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      hcount_q      <= hcount_d;
      vcount_q      <= vcount_d;
      vde_q         <= vde_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      cd_q          <= cd_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign hcount      = hcount_q;
  assign vcount      = vcount_q;
  assign vde         = vde_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign cd          = cd_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

`ifdef VIDEO_TEST_PATTERN_EN
  localparam int BAR_W = H_ACTIVE / 8;

  logic [2:0]  bar_d;
  logic [23:0] rgb_d;
  logic [23:0] rgb_q;

  // Bar index of the next pixel: counts how many bar boundaries it has passed.
  always_comb begin
    bar_d = 3'd0;
    for (int k = 1; k < 8; k++) begin
      if (hcount_d >= 12'(k * BAR_W)) begin
        bar_d = bar_d + 3'd1;
      end else begin
        bar_d = bar_d;
      end
    end
  end

  // Bar colour lookup, blanked outside the active area so it tracks vde.
  always_comb begin
    rgb_d = 24'h000000;
    if (vde_d) begin
      case (bar_d)
        3'd0:    rgb_d = 24'hFFFFFF; // white
        3'd1:    rgb_d = 24'hFFFF00; // yellow
        3'd2:    rgb_d = 24'h00FFFF; // cyan
        3'd3:    rgb_d = 24'h00FF00; // green
        3'd4:    rgb_d = 24'hFF00FF; // magenta
        3'd5:    rgb_d = 24'hFF0000; // red
        3'd6:    rgb_d = 24'h0000FF; // blue
        3'd7:    rgb_d = 24'h000000; // black
        default: rgb_d = 24'h000000;
      endcase
    end else begin
      rgb_d = 24'h000000;
    end
  end

  // Pixel colour register, loaded on the same edge as vde.
  always_ff @(posedge clk) begin
    if (rst) begin
      rgb_q <= 24'h000000;
    end else begin
      rgb_q <= rgb_d;
    end
  end

  assign red   = rgb_q[23:16];
  assign green = rgb_q[15:8];
  assign blue  = rgb_q[7:0];
`endif

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: a full-size 640x480 instance and a scaled-down
// instance (whole frames fit in a short run) share clk/rst/en. A behavioural
// raster model pushes the expected outputs of each cycle into a scoreboard,
// and they are popped and compared once the DUT edge has happened.

module tb_video_timing_gen;

  typedef struct packed {
    int ha; int hf; int hs; int hb;
    int va; int vf; int vs; int vb;
    bit hp; bit vp;
  } tim_t;

  typedef struct packed {
    logic [11:0] h;
    logic [11:0] v;
    logic        vde;
    logic        hs;
    logic        vs;
    logic [1:0]  cd;
    logic        ls;
    logic        fs;
    logic [23:0] rgb;
  } exp_t;

  // Scaled raster: 24 x 13 = 312 cycles per frame, active-high hsync.
  localparam int SH_A = 16, SH_F = 2, SH_S = 3, SH_B = 3;
  localparam int SV_A = 6,  SV_F = 2, SV_S = 2, SV_B = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b0;

  logic [11:0] d_hcount, d_vcount, s_hcount, s_vcount;
  logic        d_vde, d_hsync, d_vsync, d_ls, d_fs;
  logic        s_vde, s_hsync, s_vsync, s_ls, s_fs;
  logic [1:0]  d_cd, s_cd;
`ifdef VIDEO_TEST_PATTERN_EN
  logic [7:0]  d_red, d_green, d_blue, s_red, s_green, s_blue;
`endif

  always #5 clk = ~clk;

  video_timing_gen u_dut (
    .clk(clk), .rst(rst), .en(en),
    .hcount(d_hcount), .vcount(d_vcount), .vde(d_vde),
    .hsync(d_hsync), .vsync(d_vsync), .cd(d_cd),
    .line_start(d_ls), .frame_start(d_fs)
`ifdef VIDEO_TEST_PATTERN_EN
    , .red(d_red), .green(d_green), .blue(d_blue)
`endif
  );

  video_timing_gen #(
    .H_ACTIVE(SH_A), .H_FP(SH_F), .H_SYNC(SH_S), .H_BP(SH_B),
    .V_ACTIVE(SV_A), .V_FP(SV_F), .V_SYNC(SV_S), .V_BP(SV_B),
    .HS_POL(1'b1), .VS_POL(1'b0)
  ) u_small (
    .clk(clk), .rst(rst), .en(en),
    .hcount(s_hcount), .vcount(s_vcount), .vde(s_vde),
    .hsync(s_hsync), .vsync(s_vsync), .cd(s_cd),
    .line_start(s_ls), .frame_start(s_fs)
`ifdef VIDEO_TEST_PATTERN_EN
    , .red(s_red), .green(s_green), .blue(s_blue)
`endif
  );

  int   n_total = 0;
  int   n_bad   = 0;
  int   cyc     = 0;
  tim_t tim [2];
  int   mh [2];
  int   mv [2];
  exp_t last [2];
  exp_t sb0 [$];
  exp_t sb1 [$];

  // directed-measurement state
  bit   measure = 1'b0;
  int   last_ls = -1;
  int   last_fs = -1;
  logic prev_vde = 1'b0;
  logic prev_hs  = 1'b1;
  logic prev_svs = 1'b1;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    if (obs !== expv) begin
      n_bad++;
      if (n_bad <= 20)
        $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  function automatic exp_t model_out(tim_t t, int h, int v, bit ls, bit fs);
    exp_t e;
    int hs0 = t.ha + t.hf;
    int vs0 = t.va + t.vf;
    int bar = h / (t.ha / 8);
    bit r, g, b;
    e.h   = 12'(h);
    e.v   = 12'(v);
    e.vde = (h < t.ha) && (v < t.va);
    e.hs  = (h >= hs0 && h < hs0 + t.hs) ? t.hp : ~t.hp;
    e.vs  = (v >= vs0 && v < vs0 + t.vs) ? t.vp : ~t.vp;
    e.cd  = {e.vs, e.hs};
    e.ls  = ls;
    e.fs  = fs;
    r = (bar == 0) || (bar == 1) || (bar == 4) || (bar == 5);
    g = (bar <= 3);
    b = (bar == 0) || (bar == 2) || (bar == 4) || (bar == 6);
    e.rgb = e.vde ? {{8{r}}, {8{g}}, {8{b}}} : 24'h000000;
    return e;
  endfunction

  task automatic model_step(input int i, input bit r, input bit e);
    exp_t x;
    tim_t t = tim[i];
    int htot = t.ha + t.hf + t.hs + t.hb;
    int vtot = t.va + t.vf + t.vs + t.vb;
    if (r) begin
      mh[i] = htot - 1;
      mv[i] = vtot - 1;
      x.h = 12'(mh[i]); x.v = 12'(mv[i]);
      x.vde = 1'b0; x.hs = ~t.hp; x.vs = ~t.vp; x.cd = {~t.vp, ~t.hp};
      x.ls = 1'b0; x.fs = 1'b0; x.rgb = 24'h000000;
    end else if (e) begin
      if (mh[i] == htot - 1) begin
        mh[i] = 0;
        mv[i] = (mv[i] == vtot - 1) ? 0 : mv[i] + 1;
      end else begin
        mh[i] = mh[i] + 1;
      end
      x = model_out(t, mh[i], mv[i], mh[i] == 0, (mh[i] == 0) && (mv[i] == 0));
    end else begin
      x = last[i];
      x.ls = 1'b0;
      x.fs = 1'b0;
    end
    last[i] = x;
    if (i == 0) sb0.push_back(x);
    else        sb1.push_back(x);
  endtask

  task automatic compare(input int i);
    exp_t x, o;
    string n = (i == 0) ? "dut" : "small";
    if (((i == 0) ? sb0.size() : sb1.size()) == 0) begin
      check_val({n, ".sb_empty"}, 32'd0, 32'd1);
      return;
    end
    if (i == 0) x = sb0.pop_front();
    else        x = sb1.pop_front();
    o = '0;
    if (i == 0) begin
      o.h = d_hcount; o.v = d_vcount; o.vde = d_vde; o.hs = d_hsync; o.vs = d_vsync;
      o.cd = d_cd; o.ls = d_ls; o.fs = d_fs;
`ifdef VIDEO_TEST_PATTERN_EN
      o.rgb = {d_red, d_green, d_blue};
`endif
    end else begin
      o.h = s_hcount; o.v = s_vcount; o.vde = s_vde; o.hs = s_hsync; o.vs = s_vsync;
      o.cd = s_cd; o.ls = s_ls; o.fs = s_fs;
`ifdef VIDEO_TEST_PATTERN_EN
      o.rgb = {s_red, s_green, s_blue};
`endif
    end
    check_val({n, ".hcount"}, 32'(o.h), 32'(x.h));
    check_val({n, ".vcount"}, 32'(o.v), 32'(x.v));
    check_val({n, ".vde"}, 32'(o.vde), 32'(x.vde));
    check_val({n, ".hsync"}, 32'(o.hs), 32'(x.hs));
    check_val({n, ".vsync"}, 32'(o.vs), 32'(x.vs));
    check_val({n, ".cd"}, 32'(o.cd), 32'(x.cd));
    check_val({n, ".line_start"}, 32'(o.ls), 32'(x.ls));
    check_val({n, ".frame_start"}, 32'(o.fs), 32'(x.fs));
`ifdef VIDEO_TEST_PATTERN_EN
    check_val({n, ".rgb"}, 32'(o.rgb), 32'(x.rgb));
`endif
  endtask

  // Directed timing measurements taken during the continuous-en phase.
  task automatic directed();
    if (measure) begin
      if (d_ls === 1'b1) begin
        if (last_ls >= 0) check_val("ls_period", 32'(cyc - last_ls), 32'd800);
        last_ls = cyc;
      end
      if (s_fs === 1'b1) begin
        if (last_fs >= 0) check_val("fs_period_small", 32'(cyc - last_fs), 32'd312);
        last_fs = cyc;
      end
      if (prev_vde === 1'b1 && d_vde === 1'b0)
        check_val("vde_fall_h", 32'(d_hcount), 32'd640);
      if (prev_hs === 1'b1 && d_hsync === 1'b0)
        check_val("hsync_low_start", 32'(d_hcount), 32'd656);
      if (prev_hs === 1'b0 && d_hsync === 1'b1)
        check_val("hsync_low_end", 32'(d_hcount), 32'd752);
      if (prev_svs === 1'b1 && s_vsync === 1'b0)
        check_val("vsync_fall_small", 32'({s_vcount, s_hcount}), 32'({12'd8, 12'd0}));
    end
    prev_vde = d_vde;
    prev_hs  = d_hsync;
    prev_svs = s_vsync;
  endtask

  task automatic step(input logic r, input logic e);
    rst = r;
    en  = e;
    model_step(0, r, e);
    model_step(1, r, e);
    @(posedge clk);
    #1;
    cyc++;
    compare(0);
    compare(1);
    directed();
  endtask

  initial begin
    tim[0] = '{640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0};
    tim[1] = '{SH_A, SH_F, SH_S, SH_B, SV_A, SV_F, SV_S, SV_B, 1'b1, 1'b0};

    // reset for three cycles
    for (int k = 0; k < 3; k++) step(1'b1, 1'b0);

    // first en after reset: (0,0) with both pulses
    measure = 1'b1;
    step(1'b0, 1'b1);
    check_val("first_frame_start", 32'(d_fs), 32'd1);
    check_val("first_line_start", 32'(d_ls), 32'd1);
    check_val("first_vde", 32'(d_vde), 32'd1);
    for (int k = 0; k < 1700; k++) step(1'b0, 1'b1);
    measure = 1'b0;

    // en toggling 1,0,1 around hcount=100
    for (int k = 0; k < 1000 && mh[0] != 99; k++) step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    check_val("toggle_h100", 32'(d_hcount), 32'd100);
    step(1'b0, 1'b0);
    check_val("hold_h100", 32'(d_hcount), 32'd100);
    step(1'b0, 1'b1);
    check_val("resume_h101", 32'(d_hcount), 32'd101);

    // mid-line reset at hcount=300, with en high to show rst priority
    for (int k = 0; k < 1000 && mh[0] != 300; k++) step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    check_val("rst_h799", 32'(d_hcount), 32'd799);
    check_val("rst_v524", 32'(d_vcount), 32'd524);
    step(1'b0, 1'b1);
    check_val("post_rst_fs", 32'(d_fs), 32'd1);

    // random en pattern with an occasional reset
    for (int k = 0; k < 900; k++) step(($urandom_range(0, 99) == 0) ? 1'b1 : 1'b0, 1'($urandom_range(0, 3) != 0));

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
